// File: rtl/bcd_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl_pkg
// Shared constants and helpers for the two-digit BCD counter / display scanner.
//   BCD_MAX            : largest legal BCD digit value.
//   AN_LO/AN_HI/AN_OFF : active-low anode patterns (ones lit, tens lit, blank).
//   clog2_f()          : counter width needed to hold 0..value-1.
// -----------------------------------------------------------------------------
package bcd_scan_ctrl_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] AN_LO  = 2'b10;
    localparam logic [1:0] AN_HI  = 2'b01;
    localparam logic [1:0] AN_OFF = 2'b11;

    // Bits needed for a counter running 0..value-1; never less than 1.
    function automatic int clog2_f(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_scan_ctrl_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD decade counter (0..9) with clear, clamped load and up/down stepping.
// Priority: clr > load > step.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0
//   load       : synchronous load of load_d (values above 9 load as 9)
//   load_d     : load value
//   step       : advance one count in the direction given by up
//   up         : 1 = increment, 0 = decrement
//   q          : current digit
//   carry_out  : step while at the boundary (9 going up, 0 going down);
//                drives the next decade's step
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_scan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       step,
    input  logic       up,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] r_q;
    logic       w_at_bound;

    assign w_at_bound = up ? (r_q == BCD_MAX) : (r_q == 4'd0);
    assign carry_out  = step && w_at_bound;
    assign q          = r_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= (load_d > BCD_MAX) ? BCD_MAX : load_d;
        end else if (step) begin
            if (w_at_bound) begin
                r_q <= up ? 4'd0 : BCD_MAX;
            end else begin
                r_q <= up ? (r_q + 4'd1) : (r_q - 4'd1);
            end
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl
// Two-digit BCD up/down counter with a tick prescaler and a two-digit display
// scan generator feeding a 4-bit 2:1 digit mux and active-low anodes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt_en     : prescaler runs only while high
//   cnt_up     : count direction on the tick cycle (1 = up)
//   clr        : synchronous clear of digits and prescaler (not the scanner)
//   load       : synchronous load of load_val (nibbles above 9 load as 9)
//   load_val   : {tens, ones} BCD load value
//   digit_lo   : ones digit (mux input A)
//   digit_hi   : tens digit (mux input B)
//   scan_sel   : 0 = ones active, 1 = tens active (mux select)
//   an         : active-low anodes, an[0] = ones, an[1] = tens
//   wrap       : one-cycle pulse with the 99->00 (up) or 00->99 (down) update
// -----------------------------------------------------------------------------
module bcd_scan_ctrl
    import bcd_scan_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cnt_en,
    input  logic       cnt_up,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] digit_lo,
    output logic [3:0] digit_hi,
    output logic       scan_sel,
    output logic [1:0] an,
    output logic       wrap
);

    localparam int PW = clog2_f(TICK_DIV);
    localparam int SW = clog2_f(SCAN_DIV);
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_scan_cnt;
    logic          r_scan_sel;
    logic          r_wrap;

    logic          w_tick;
    logic          w_lo_carry;
    logic          w_hi_carry;

    // clr and load both outrank the tick, so a coincident tick is dropped.
    assign w_tick = cnt_en && !clr && !load && (r_presc == P_MAX);

    // ---------------------------------------------------------------- prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clr || load) begin
            r_presc <= '0;
        end else if (cnt_en) begin
            r_presc <= (r_presc == P_MAX) ? '0 : (r_presc + 1'b1);
        end
    end

    // ------------------------------------------------------------------ digits
    bcd_digit u_digit_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_d    (load_val[3:0]),
        .step      (w_tick),
        .up        (cnt_up),
        .q         (digit_lo),
        .carry_out (w_lo_carry)
    );

    bcd_digit u_digit_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_d    (load_val[7:4]),
        .step      (w_lo_carry),
        .up        (cnt_up),
        .q         (digit_hi),
        .carry_out (w_hi_carry)
    );

    // A tens-digit carry only happens on the 99->00 / 00->99 step, so
    // registering it lines the pulse up with the digit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else if (clr || load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_hi_carry;
        end
    end

    assign wrap = r_wrap;

    // ------------------------------------------------------------- scan logic
    // Free-running: deliberately ignores cnt_en, clr and load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_sel <= 1'b0;
        end else if (r_scan_cnt == S_MAX) begin
            r_scan_cnt <= '0;
            r_scan_sel <= ~r_scan_sel;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign scan_sel = r_scan_sel;

    // NOTE: an always_comb output gets a default before any branching so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        an = AN_OFF;
        case (r_scan_sel)
            1'b0:    an = AN_LO;
            1'b1:    an = AN_HI;
            default: an = AN_OFF;
        endcase
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_ctrl
// Directed bench for bcd_scan_ctrl with TICK_DIV=4, SCAN_DIV=3. Inputs change
// and outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cnt_en;
    logic       cnt_up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] digit_lo;
    logic [3:0] digit_hi;
    logic       scan_sel;
    logic [1:0] an;
    logic       wrap;

    int total;
    int bad;

    bcd_scan_ctrl #(
        .TICK_DIV (4),
        .SCAN_DIV (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .digit_lo (digit_lo),
        .digit_hi (digit_hi),
        .scan_sel (scan_sel),
        .an       (an),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        cnt_en   = 1'b0;
        cnt_up   = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;

        // ---- reset and scan
        step(2);
        check("rst_digits", 16'({digit_hi, digit_lo}), 16'h00);
        check("rst_an", 16'(an), 16'h2);
        check("rst_scan_sel", 16'(scan_sel), 16'h0);
        check("rst_wrap", 16'(wrap), 16'h0);
        rst_n = 1'b1;
        step(2);
        check("scan_hold_lo", 16'(an), 16'h2);
        step(1);
        check("scan_tog_hi", 16'(an), 16'h1);
        check("scan_sel_hi", 16'(scan_sel), 16'h1);
        step(3);
        check("scan_tog_lo", 16'(an), 16'h2);
        check("idle_digits", 16'({digit_hi, digit_lo}), 16'h00);

        // ---- count up with carry
        cnt_en = 1'b1;
        cnt_up = 1'b1;
        do_load(8'h08);
        check("load_08", 16'({digit_hi, digit_lo}), 16'h08);
        step(3);
        check("pre_tick_08", 16'({digit_hi, digit_lo}), 16'h08);
        step(1);
        check("up_09", 16'({digit_hi, digit_lo}), 16'h09);
        step(4);
        check("up_carry_10", 16'({digit_hi, digit_lo}), 16'h10);
        check("up_carry_nowrap", 16'(wrap), 16'h0);

        // ---- hold while disabled
        cnt_en = 1'b0;
        step(8);
        check("hold_10", 16'({digit_hi, digit_lo}), 16'h10);
        cnt_en = 1'b1;

        // ---- up wrap
        do_load(8'h98);
        step(4);
        check("up_99", 16'({digit_hi, digit_lo}), 16'h99);
        check("up_99_nowrap", 16'(wrap), 16'h0);
        step(4);
        check("up_wrap_00", 16'({digit_hi, digit_lo}), 16'h00);
        check("up_wrap_pulse", 16'(wrap), 16'h1);
        step(1);
        check("up_wrap_end", 16'(wrap), 16'h0);

        // ---- down wrap and borrow
        cnt_up = 1'b0;
        do_load(8'h01);
        step(4);
        check("dn_00", 16'({digit_hi, digit_lo}), 16'h00);
        check("dn_00_nowrap", 16'(wrap), 16'h0);
        step(4);
        check("dn_wrap_99", 16'({digit_hi, digit_lo}), 16'h99);
        check("dn_wrap_pulse", 16'(wrap), 16'h1);
        step(1);
        check("dn_wrap_end", 16'(wrap), 16'h0);
        step(3);
        check("dn_98", 16'({digit_hi, digit_lo}), 16'h98);
        do_load(8'h10);
        step(4);
        check("dn_borrow_09", 16'({digit_hi, digit_lo}), 16'h09);
        check("dn_borrow_nowrap", 16'(wrap), 16'h0);

        // ---- load clamp and priority
        cnt_en = 1'b0;
        do_load(8'hAF);
        check("clamp_99", 16'({digit_hi, digit_lo}), 16'h99);
        check("clamp_nowrap", 16'(wrap), 16'h0);
        clr = 1'b1;
        do_load(8'h55);
        clr = 1'b0;
        check("clr_over_load", 16'({digit_hi, digit_lo}), 16'h00);
        cnt_en = 1'b1;
        cnt_up = 1'b1;
        do_load(8'h20);
        step(3);
        check("pre_tick_20", 16'({digit_hi, digit_lo}), 16'h20);
        do_load(8'h45);
        check("load_beats_tick", 16'({digit_hi, digit_lo}), 16'h45);
        step(3);
        check("presc_restart", 16'({digit_hi, digit_lo}), 16'h45);
        step(1);
        check("tick_after_load", 16'({digit_hi, digit_lo}), 16'h46);

        // ---- async reset mid-count
        do_load(8'h57);
        step(2);
        check("pre_rst_57", 16'({digit_hi, digit_lo}), 16'h57);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_digits", 16'({digit_hi, digit_lo}), 16'h00);
        check("async_an", 16'(an), 16'h2);
        check("async_scan_sel", 16'(scan_sel), 16'h0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("post_rst_wait", 16'({digit_hi, digit_lo}), 16'h00);
        step(1);
        check("post_rst_tick", 16'({digit_hi, digit_lo}), 16'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
